crc_16_arbiter: RTL and testbench
=================================

// Module: crc_16_arbiter
// PURPOSE
//  Shares one crc_16 engine between NREQ requesters, e.g. the J1 CPU
//  peripheral path and a UART frame checker.
//  - Round-robin arbitration among active requests.
//  - Drives the engine's data_in and start, then waits for done.
//  - Returns the 17-bit result to the granted requester only.
// PARAMETERS
//  NREQ     2    number of requesters (2..8)
//  DW       32   engine data_in width
//  RW       17   engine data_out width
//  TIMEOUT  64   done watchdog limit in cycles (used only with CRC_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1         system clock; all logic on posedge
//  rst          in   1         synchronous reset, active-high
//  req_i        in   NREQ      level request; held high until gnt_o bit seen
//  req_data_i   in   NREQ*DW   per-requester operand; slice k = [k*DW +: DW]
//  gnt_o        out  NREQ      one-hot, 1-cycle pulse: operand captured
//  rsp_valid_o  out  NREQ      one-hot, 1-cycle pulse: rsp_data_o valid for owner
//  rsp_data_o   out  RW        result register; holds until next completion
//  rsp_err_o    out  1         high with rsp_valid_o when a job timed out
//  busy_o       out  1         high in every state except IDLE
//  eng_data_o   out  DW        to crc_16 data_in; registered, stable START..DONE
//  eng_start_o  out  1         to crc_16 start; 1-cycle pulse per job
//  eng_data_i   in   RW        from crc_16 data_out
//  eng_done_i   in   1         from crc_16 done
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; rr pointer ptr=0; watchdog=0.
//  FSM states: IDLE -> START -> WAIT -> DONE -> IDLE.
//  IDLE
//   - if req_i!=0, pick the first set bit scanning ptr, ptr+1, ... mod NREQ;
//     call it the owner.
//   - eng_data_o <= owner's slice; gnt_o[owner] <= 1; go to START.
//   - if req_i==0, stay in IDLE.
//  START
//   - eng_start_o=1 for exactly this cycle; go to WAIT.
//   - set holdoff flag; clear watchdog.
//  WAIT
//   - first WAIT cycle: ignore eng_done_i (engine may still show the stale
//     done); clear holdoff.
//   - afterwards, on eng_done_i=1: rsp_data_o <= eng_data_i; go to DONE.
//  DONE
//   - rsp_valid_o[owner]=1 for one cycle.
//   - ptr <= (owner+1) mod NREQ; go to IDLE.
//  Latency
//   - req_i to gnt_o: 1 cycle.
//   - gnt_o to eng_start_o: 1 cycle.
//   - eng_done_i to rsp_valid_o: 1 cycle.
//   - minimum job length: 5 cycles from IDLE back to IDLE.
//  Boundary cases
//   - req_i dropped after grant: the job still completes and responds.
//   - requests arriving while busy are queued only by their level; they are
//     not latched.
//   - the owner re-requesting in the DONE cycle loses to any other pending
//     requester (ptr has advanced).
//   - NREQ not a power of 2: ptr wraps NREQ-1 -> 0.
//   - rst mid-job: immediate return to IDLE; no rsp_valid_o; ptr=0; the
//     engine is reset by the same rst.
//   - eng_done_i stuck high: ignored only in the holdoff cycle.
// CONFIGURATION
//  Macro CRC_ARB_TIMEOUT_EN.
//  Defined:
//   - an 8-bit watchdog counts WAIT cycles.
//   - at count TIMEOUT-1 with no done: rsp_data_o <= 0, rsp_err_o <= 1,
//     go to DONE (normal response pulse).
//   - rsp_err_o clears on the next DONE without timeout.
//  Undefined:
//   - no watchdog logic; rsp_err_o tied 0; WAIT may last forever.
// TESTING
//  1. req_i=01, data0=0x12345678; engine model sets done 8 cycles after start
//     with 0x0BEEF -> gnt_o=01 at cycle 1, start at cycle 2,
//     rsp_valid_o=01 with rsp_data_o=0x0BEEF.
//  2. Out of reset, req_i=11 held -> first job goes to req0; second job is
//     granted to req1 in the cycle after req0's DONE.
//  3. req_i=11 held for 4 jobs -> grant order 0,1,0,1; never two consecutive
//     grants to the same requester.
//  4. done already high at start (stale) -> ignored in holdoff; completion
//     occurs only on the model's fresh done; the result is the new value.
//  5. rst pulsed in WAIT -> next cycle all outputs 0, busy_o=0, no
//     rsp_valid_o; a new req1 is granted normally.
//  6. CRC_ARB_TIMEOUT_EN, TIMEOUT=16, done never asserted ->
//     rsp_valid_o[owner]=1, rsp_err_o=1, rsp_data_o=0 at 16 WAIT cycles.

Source files
------------

// File: rtl/crc_16_arbiter_if.sv
// Requester-side bus of crc_16_arbiter: level requests with packed operands in,
// one-hot grant/response pulses and the shared result register out.
interface crc_16_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int RW   = 17
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [RW-1:0]      rsp_data;
    logic               rsp_err;
    logic               busy;

    modport master (
        output req, req_data,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req, req_data,
        output gnt, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/crc_16_arbiter.sv
// Round-robin sharing of one crc_16 engine among NREQ requesters.
// Optional done watchdog enabled by macro CRC_ARB_TIMEOUT_EN (adds parameter TIMEOUT).
module crc_16_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int RW   = 17
`ifdef CRC_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    crc_16_arbiter_if.slave      bus,
    output logic [DW-1:0]        eng_data,
    output logic                 eng_start,
    input  logic [RW-1:0]        eng_result,
    input  logic                 eng_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     ptr_r, ptr_s, owner_r, owner_s, pick_s, idx_s;
    logic [PW:0]       sum_s;
    logic              pick_valid_s;
    logic [NREQ-1:0]   gnt_r, gnt_s, rsp_valid_r, rsp_valid_s;
    logic [RW-1:0]     rsp_data_r, rsp_data_s;
    logic [DW-1:0]     eng_data_r, eng_data_s;
    logic              eng_start_r, eng_start_s;
    logic              holdoff_r, holdoff_s;
    logic              busy_r;
`ifdef CRC_ARB_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);
    logic              rsp_err_r, rsp_err_s;
    logic [7:0]        wdog_r, wdog_s;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] k);
        logic [NREQ-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    // Round-robin pick: scan downwards so the request closest to ptr wins.
    always_comb begin
        pick_s       = ptr_r;
        pick_valid_s = 1'b0;
        sum_s        = '0;
        idx_s        = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum_s = {1'b0, ptr_r} + (PW+1)'(i);
            idx_s = (sum_s >= NREQ_W) ? PW'(sum_s - NREQ_W) : PW'(sum_s);
            if (bus.req[idx_s]) begin
                pick_s       = idx_s;
                pick_valid_s = 1'b1;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Next-state and next-output logic of the job FSM.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        owner_s     = owner_r;
        gnt_s       = '0;
        rsp_valid_s = '0;
        rsp_data_s  = rsp_data_r;
        eng_data_s  = eng_data_r;
        eng_start_s = 1'b0;
        holdoff_s   = holdoff_r;
`ifdef CRC_ARB_TIMEOUT_EN
        rsp_err_s   = rsp_err_r;
        wdog_s      = wdog_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    owner_s    = pick_s;
                    eng_data_s = bus.req_data[pick_s*DW +: DW];
                    gnt_s      = onehot(pick_s);
                    state_s    = START;
                end else begin
                    state_s    = IDLE;
                end
            end
            START: begin
                eng_start_s = 1'b1;
                holdoff_s   = 1'b1;
`ifdef CRC_ARB_TIMEOUT_EN
                wdog_s      = 8'd0;
`endif
                state_s     = WAIT;
            end
            WAIT: begin
                // The engine's done may still be left over from the previous job
                // during the first WAIT cycle, so it only counts afterwards.
                holdoff_s = 1'b0;
                if (!holdoff_r && eng_done) begin
                    rsp_data_s  = eng_result;
                    rsp_valid_s = onehot(owner_r);
`ifdef CRC_ARB_TIMEOUT_EN
                    rsp_err_s   = 1'b0;
`endif
                    state_s     = DONE;
                end else begin
`ifdef CRC_ARB_TIMEOUT_EN
                    if (wdog_r == WDOG_LIMIT) begin
                        rsp_data_s  = '0;
                        rsp_err_s   = 1'b1;
                        rsp_valid_s = onehot(owner_r);
                        state_s     = DONE;
                    end else begin
                        wdog_s      = wdog_r + 8'd1;
                    end
`else
                    state_s = WAIT;
`endif
                end
            end
            DONE: begin
                ptr_s   = (owner_r == LAST) ? '0 : owner_r + PW'(1'b1);
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            owner_r     <= '0;
            gnt_r       <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            eng_data_r  <= '0;
            eng_start_r <= 1'b0;
            holdoff_r   <= 1'b0;
            busy_r      <= 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
            rsp_err_r   <= 1'b0;
            wdog_r      <= 8'd0;
`endif
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            owner_r     <= owner_s;
            gnt_r       <= gnt_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
            eng_data_r  <= eng_data_s;
            eng_start_r <= eng_start_s;
            holdoff_r   <= holdoff_s;
            busy_r      <= (state_s != IDLE);
`ifdef CRC_ARB_TIMEOUT_EN
            rsp_err_r   <= rsp_err_s;
            wdog_r      <= wdog_s;
`endif
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;
    assign eng_data      = eng_data_r;
    assign eng_start     = eng_start_r;
`ifdef CRC_ARB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_r;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_crc_16_arbiter.sv
// Scoreboard bench for crc_16_arbiter with a behavioural crc_16 engine model.
module tb_crc_16_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int RW   = 17;
`ifdef CRC_ARB_TIMEOUT_EN
    localparam int TMO  = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc_16_arbiter_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();
    logic [DW-1:0] eng_data;
    logic          eng_start;
    logic [RW-1:0] eng_result;
    logic          eng_done;

    crc_16_arbiter #(
        .NREQ(NREQ), .DW(DW), .RW(RW)
`ifdef CRC_ARB_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .eng_data(eng_data), .eng_start(eng_start),
        .eng_result(eng_result), .eng_done(eng_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Engine model: done rises 8 cycles after start and then stays high (stale).
    logic [RW-1:0] salt     = 17'h0;
    logic          eng_mute = 1'b0;
    int            ecnt;
    logic [RW-1:0] epend;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            eng_done   <= 1'b0;
            eng_result <= '0;
            ecnt       <= 0;
        end else if (eng_start) begin
            eng_done <= 1'b0;
            ecnt     <= 7;
            epend    <= eng_data[RW-1:0] ^ salt;
        end else if (ecnt != 0) begin
            ecnt <= ecnt - 1;
            if (ecnt == 1 && !eng_mute) begin
                eng_done   <= 1'b1;
                eng_result <= epend;
            end
        end
    end

    // Scoreboard: expected grant order queued by tests; response expectation
    // queued when the grant appears, compared when rsp_valid fires.
    typedef struct {
        int            owner;
        logic [RW-1:0] data;
        logic          err;
    } rsp_t;
    int   exp_gnt_q[$];
    rsp_t rsp_q[$];
    logic exp_tmo = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.gnt != '0) begin
                tests++;
                if (exp_gnt_q.size() == 0) begin
                    fails++;
                    $display("FAIL gnt_unexpected: got %b, required none", bus.gnt);
                end else begin
                    int o;
                    logic [NREQ-1:0] oh;
                    rsp_t r;
                    o     = exp_gnt_q.pop_front();
                    oh    = '0;
                    oh[o] = 1'b1;
                    if (bus.gnt !== oh) begin
                        fails++;
                        $display("FAIL gnt_order: got %b, required %b", bus.gnt, oh);
                    end
                    r.owner = o;
                    r.err   = exp_tmo;
                    r.data  = exp_tmo ? '0 : (bus.req_data[o*DW +: RW] ^ salt);
                    rsp_q.push_back(r);
                end
            end
            if (bus.rsp_valid != '0) begin
                tests++;
                if (rsp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: got valid=%b data=%h", bus.rsp_valid, bus.rsp_data);
                end else begin
                    rsp_t r;
                    logic [NREQ-1:0] oh;
                    r           = rsp_q.pop_front();
                    oh          = '0;
                    oh[r.owner] = 1'b1;
                    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err} !== {oh, r.data, r.err}) begin
                        fails++;
                        $display("FAIL rsp_data: got valid=%b data=%h err=%b, required valid=%b data=%h err=%b",
                                 bus.rsp_valid, bus.rsp_data, bus.rsp_err, oh, r.data, r.err);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for rsp_valid, returning cycles elapsed since entry (-1 on timeout).
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.rsp_valid != '0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        tick();
        tick();
        tests++;
        if ({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy, eng_start, eng_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h err=%b busy=%b st=%b ed=%h, required all 0",
                     bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy, eng_start, eng_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int lat;
        salt = 17'h0BEEF ^ 17'h05678;
        bus.req_data[0*DW +: DW] = 32'h1234_5678;
        exp_gnt_q.push_back(0);
        bus.req = 2'b01;
        tick();
        tests++;
        if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL single_gnt: got gnt=%b busy=%b, required 01/1", bus.gnt, bus.busy);
        end
        bus.req = 2'b00;
        tick();
        tests++;
        if (eng_start !== 1'b1 || eng_data !== 32'h1234_5678 || bus.gnt !== 2'b00) begin
            fails++;
            $display("FAIL single_start: got start=%b data=%h gnt=%b, required 1/12345678/00",
                     eng_start, eng_data, bus.gnt);
        end
        wait_rsp(lat);
        tests++;
        if (lat != 9 || bus.rsp_valid !== 2'b01 || bus.rsp_data !== 17'h0BEEF) begin
            fails++;
            $display("FAIL single_rsp: got lat=%0d valid=%b data=%h, required 9/01/0beef",
                     lat, bus.rsp_valid, bus.rsp_data);
        end
        tick();
        tests++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_data !== 17'h0BEEF) begin
            fails++;
            $display("FAIL single_idle: got busy=%b valid=%b data=%h, required 0/00/0beef",
                     bus.busy, bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_stale_done();
        int lat;
        logic stale;
        bus.req_data[1*DW +: DW] = 32'h0000_A5A5;
        exp_gnt_q.push_back(1);
        bus.req = 2'b10;
        tick();
        bus.req = 2'b00;
        tick();
        stale = eng_done;
        tests++;
        if (eng_start !== 1'b1 || stale !== 1'b1) begin
            fails++;
            $display("FAIL stale_setup: got start=%b done=%b, required 1/1", eng_start, stale);
        end
        wait_rsp(lat);
        tests++;
        if (lat != 9 || bus.rsp_data !== (17'h0A5A5 ^ salt)) begin
            fails++;
            $display("FAIL stale_holdoff: got lat=%0d data=%h, required 9/%h",
                     lat, bus.rsp_data, 17'h0A5A5 ^ salt);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int order[4];
        int gcyc[4];
        int rcyc[4];
        int ng = 0;
        int nr = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        salt = 17'h1F00F;
        bus.req_data = {32'h3333_4444, 32'h1111_2222};
        for (int k = 0; k < 4; k++) exp_gnt_q.push_back(k % 2);
        bus.req = 2'b11;
        for (int i = 0; i < 200 && nr < 4; i++) begin
            tick();
            if (bus.gnt != '0 && ng < 4) begin
                order[ng] = (bus.gnt == 2'b01) ? 0 : 1;
                gcyc[ng]  = i;
                ng++;
                if (ng == 4) bus.req = 2'b00;
            end
            if (bus.rsp_valid != '0 && nr < 4) begin
                rcyc[nr] = i;
                nr++;
            end
        end
        tests++;
        if (ng != 4 || nr != 4) begin
            fails++;
            $display("FAIL rr_count: got %0d grants %0d responses, required 4/4", ng, nr);
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (order[k] != k % 2) begin
                    fails++;
                    $display("FAIL rr_order[%0d]: got owner %0d, required %0d", k, order[k], k % 2);
                end
            end
            tests++;
            if (gcyc[1] - rcyc[0] != 2) begin
                fails++;
                $display("FAIL rr_gap: got %0d cycles from rsp0 to gnt1, required 2", gcyc[1] - rcyc[0]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_job();
        int lat;
        int extra = 0;
        salt = 17'h00001;
        bus.req_data = {32'hCAFE_0001, 32'hDEAD_0002};
        exp_gnt_q.push_back(0);
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        tick();
        tick();
        rst = 1'b1;
        rsp_q.delete();
        tick();
        tests++;
        if ({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy, eng_start, eng_data} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got gnt=%b rv=%b rd=%h busy=%b st=%b ed=%h, required all 0",
                     bus.gnt, bus.rsp_valid, bus.rsp_data, bus.busy, eng_start, eng_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.rsp_valid != '0 || bus.busy != 1'b0) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL rst_mid_quiet: got %0d active cycles, required 0", extra);
        end
        exp_gnt_q.push_back(1);
        bus.req = 2'b10;
        tick();
        tests++;
        if (bus.gnt !== 2'b10) begin
            fails++;
            $display("FAIL rst_mid_regrant: got gnt=%b, required 10", bus.gnt);
        end
        bus.req = 2'b00;
        tick();
        wait_rsp(lat);
        tests++;
        if (lat != 9 || bus.rsp_valid !== 2'b10) begin
            fails++;
            $display("FAIL rst_mid_rsp: got lat=%0d valid=%b, required 9/10", lat, bus.rsp_valid);
        end
        tick();
    endtask

`ifdef CRC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        eng_mute = 1'b1;
        exp_tmo  = 1'b1;
        exp_gnt_q.push_back(0);
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        wait_rsp(lat);
        tests++;
        if (lat != TMO || bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_data !== '0) begin
            fails++;
            $display("FAIL timeout_rsp: got lat=%0d valid=%b err=%b data=%h, required %0d/01/1/0",
                     lat, bus.rsp_valid, bus.rsp_err, bus.rsp_data, TMO);
        end
        tick();
        eng_mute = 1'b0;
        exp_tmo  = 1'b0;
        exp_gnt_q.push_back(1);
        bus.req = 2'b10;
        tick();
        bus.req = 2'b00;
        wait_rsp(lat);
        tests++;
        if (bus.rsp_err !== 1'b0 || lat < 0) begin
            fails++;
            $display("FAIL timeout_clear: got err=%b lat=%0d, required 0", bus.rsp_err, lat);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stale_done();
        test_round_robin();
        test_reset_mid_job();
`ifdef CRC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (4) tick();
        tests++;
        if (exp_gnt_q.size() != 0 || rsp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d grants %0d responses pending, required 0/0",
                     exp_gnt_q.size(), rsp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
